// File: rtl/datapath_pkg.sv
// -----------------------------------------------------------------------------
// datapath_pkg
// Shared encodings for the self-sequencing datapath: ALU op and B-shifter
// codes, the sequencer state enum, the {V,N,Z} status bit positions and a
// helper that sizes register-address fields from the register-file depth.
// -----------------------------------------------------------------------------
package datapath_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_MVN = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_EXEC  = 2'b10,
    ST_WRITE = 2'b11
  } state_e;

  // Bit positions inside the 3-bit status word {V,N,Z}.
  localparam int unsigned STAT_V = 2;
  localparam int unsigned STAT_N = 1;
  localparam int unsigned STAT_Z = 0;

  // Register-address width for a register file of depth n (never below 1).
  function automatic int unsigned rw_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/datapath_seq_if.sv
// -----------------------------------------------------------------------------
// datapath_seq_if
// Request/completion bundle between a controller (master) and datapath_seq
// (slave). One register-transfer operation is offered per req_valid/req_ready
// handshake; done pulses once when its write-back stage has finished.
//   req_valid/req_ready : handshake, accepted when both high at a rising edge
//   req_op, req_shift   : ALU operation and B-operand shift
//   req_rn/rm/rd        : A source, B source, destination register
//   req_asel_zero       : A operand forced to 0
//   req_bsel_imm        : B operand taken from req_imm
//   req_write           : perform register write-back
//   req_vsel_in         : write back external data instead of C
//   req_loads           : update status flags
//   done                : one-cycle completion pulse
// -----------------------------------------------------------------------------
interface datapath_seq_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
);

  localparam int RW = datapath_pkg::rw_of(NREGS);

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [1:0]       req_shift;
  logic [RW-1:0]    req_rn;
  logic [RW-1:0]    req_rm;
  logic [RW-1:0]    req_rd;
  logic             req_asel_zero;
  logic             req_bsel_imm;
  logic [WIDTH-1:0] req_imm;
  logic             req_write;
  logic             req_vsel_in;
  logic             req_loads;
  logic             done;

  modport master (
    output req_valid, req_op, req_shift, req_rn, req_rm, req_rd,
           req_asel_zero, req_bsel_imm, req_imm, req_write, req_vsel_in,
           req_loads,
    input  req_ready, done
  );

  modport slave (
    input  req_valid, req_op, req_shift, req_rn, req_rm, req_rd,
           req_asel_zero, req_bsel_imm, req_imm, req_write, req_vsel_in,
           req_loads,
    output req_ready, done
  );

endinterface

// File: rtl/datapath_seq_regfile.sv
// -----------------------------------------------------------------------------
// datapath_seq_regfile
// NREGS x WIDTH register file with one write port, two read selects whose
// data the sequencer captures into its A/B registers, and a combinational
// debug read port. All entries clear asynchronously on rst; entry 0 is an
// ordinary writable register.
//   clk, rst               : clock, async active-high reset
//   i_we, i_waddr, i_wdata : write port (takes effect at the rising edge)
//   i_raddr_a/o_rdata_a    : A read select / data
//   i_raddr_b/o_rdata_b    : B read select / data
//   i_dbg_addr/o_dbg_data  : debug read
// -----------------------------------------------------------------------------
module datapath_seq_regfile
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_we,
  input  logic [rw_of(NREGS)-1:0]   i_waddr,
  input  logic [WIDTH-1:0]          i_wdata,
  input  logic [rw_of(NREGS)-1:0]   i_raddr_a,
  input  logic [rw_of(NREGS)-1:0]   i_raddr_b,
  input  logic [rw_of(NREGS)-1:0]   i_dbg_addr,
  output logic [WIDTH-1:0]          o_rdata_a,
  output logic [WIDTH-1:0]          o_rdata_b,
  output logic [WIDTH-1:0]          o_dbg_data
);

  logic [WIDTH-1:0] r_mem [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_mem[i_raddr_a];
  assign o_rdata_b  = r_mem[i_raddr_b];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/datapath_seq.sv
// -----------------------------------------------------------------------------
// datapath_seq
// Self-sequencing register-transfer datapath. A request accepted in IDLE is
// latched into an op register and then walks READ -> EXEC -> WRITE -> IDLE:
//   READ  : A/B operands captured from the register file or immediate/zero
//   EXEC  : B shifted, ALU result captured into C, optional {V,N,Z} update
//   WRITE : optional write-back of C or datapath_in; done pulses next cycle
// Ports:
//   clk, reset     : clock, async active-high reset (clears all state)
//   bus            : request/completion interface (slave side)
//   datapath_in    : external write-back data, sampled at the WRITE edge
//   datapath_out   : C register
//   status         : {V,N,Z}
//   dbg_addr/data  : combinational register-file peek
// -----------------------------------------------------------------------------
module datapath_seq
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  datapath_seq_if.slave            bus,
  input  logic [WIDTH-1:0]         datapath_in,
  output logic [WIDTH-1:0]         datapath_out,
  output logic [2:0]               status,
  input  logic [rw_of(NREGS)-1:0]  dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);

  localparam int RW = rw_of(NREGS);

  // Sequencer
  state_e                   r_state;
  state_e                   w_next;
  logic                     w_ready;
  logic                     w_accept;
  logic                     w_we;

  // Op register
  alu_op_e                  r_op;
  shift_e                   r_shift;
  logic [RW-1:0]            r_rn;
  logic [RW-1:0]            r_rm;
  logic [RW-1:0]            r_rd;
  logic                     r_asel_zero;
  logic                     r_bsel_imm;
  logic [WIDTH-1:0]         r_imm;
  logic                     r_write;
  logic                     r_vsel_in;
  logic                     r_loads;

  // Datapath
  logic signed [WIDTH-1:0]  r_a;
  logic signed [WIDTH-1:0]  r_b;
  logic signed [WIDTH-1:0]  r_c;
  logic [2:0]               r_status;
  logic                     r_done;
  logic [WIDTH-1:0]         w_rdata_a;
  logic [WIDTH-1:0]         w_rdata_b;
  logic [WIDTH-1:0]         w_wdata;
  logic signed [WIDTH-1:0]  w_bs;
  logic signed [WIDTH-1:0]  w_result;
  logic                     w_ovf;

  // One-position B shifter; LSR fills with zero, ASR replicates the sign.
  function automatic logic signed [WIDTH-1:0] f_shift(
    input logic signed [WIDTH-1:0] b,
    input shift_e                  sh
  );
    case (sh)
      SH_LSL1: f_shift = b <<< 1;
      SH_LSR1: f_shift = $signed({1'b0, b[WIDTH-1:1]});
      SH_ASR1: f_shift = b >>> 1;
      default: f_shift = b;
    endcase
  endfunction

  // ALU returning {overflow, result}. Overflow is the two's-complement
  // signed overflow of ADD/SUB and is always 0 for the logic ops.
  function automatic logic [WIDTH:0] f_alu(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input alu_op_e                 op
  );
    logic signed [WIDTH-1:0] r;
    logic                    v;
    r = '0;
    v = 1'b0;
    case (op)
      ALU_ADD: begin
        r = a + b;
        v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        r = a - b;
        v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: r = a & b;
      default: r = ~b;
    endcase
    f_alu = {v, r};
  endfunction

  // Sequencer: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Sequencer: next state and per-state strobes
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.req_valid) begin
          w_next = ST_READ;
        end
      end
      ST_READ:  w_next = ST_EXEC;
      ST_EXEC:  w_next = ST_WRITE;
      ST_WRITE: begin
        w_next = ST_IDLE;
        w_we   = r_write;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  assign w_accept = w_ready & bus.req_valid;

  // Accept: request fields frozen for the whole operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op        <= ALU_ADD;
      r_shift     <= SH_NONE;
      r_rn        <= '0;
      r_rm        <= '0;
      r_rd        <= '0;
      r_asel_zero <= 1'b0;
      r_bsel_imm  <= 1'b0;
      r_imm       <= '0;
      r_write     <= 1'b0;
      r_vsel_in   <= 1'b0;
      r_loads     <= 1'b0;
    end else if (w_accept) begin
      r_op        <= alu_op_e'(bus.req_op);
      r_shift     <= shift_e'(bus.req_shift);
      r_rn        <= bus.req_rn;
      r_rm        <= bus.req_rm;
      r_rd        <= bus.req_rd;
      r_asel_zero <= bus.req_asel_zero;
      r_bsel_imm  <= bus.req_bsel_imm;
      r_imm       <= bus.req_imm;
      r_write     <= bus.req_write;
      r_vsel_in   <= bus.req_vsel_in;
      r_loads     <= bus.req_loads;
    end
  end

  assign w_bs                = f_shift(r_b, r_shift);
  assign {w_ovf, w_result}   = f_alu(r_a, w_bs, r_op);

  // READ -> EXEC boundary: operand capture; EXEC -> WRITE boundary: C/flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_status <= '0;
    end else begin
      case (r_state)
        ST_READ: begin
          r_a <= r_asel_zero ? '0 : $signed(w_rdata_a);
          r_b <= r_bsel_imm ? $signed(r_imm) : $signed(w_rdata_b);
        end
        ST_EXEC: begin
          r_c <= w_result;
          if (r_loads) begin
            r_status[STAT_Z] <= (w_result == '0);
            r_status[STAT_N] <= w_result[WIDTH-1];
            r_status[STAT_V] <= w_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  // WRITE -> IDLE boundary: completion pulse for the cycle after write-back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_WRITE);
    end
  end

  assign w_wdata = r_vsel_in ? datapath_in : r_c;

  datapath_seq_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk        (clk),
    .rst        (reset),
    .i_we       (w_we),
    .i_waddr    (r_rd),
    .i_wdata    (w_wdata),
    .i_raddr_a  (r_rn),
    .i_raddr_b  (r_rm),
    .i_dbg_addr (dbg_addr),
    .o_rdata_a  (w_rdata_a),
    .o_rdata_b  (w_rdata_b),
    .o_dbg_data (dbg_data)
  );

  assign bus.req_ready = w_ready;
  assign bus.done      = r_done;
  assign datapath_out  = r_c;
  assign status        = r_status;

endmodule

// File: tb/tb_datapath_seq.sv
// -----------------------------------------------------------------------------
// tb_datapath_seq
// Two datapath_seq instances run in lockstep from the same directed requests:
// instance A at WIDTH=16/NREGS=8 and instance B at WIDTH=8/NREGS=16. Expected
// values are written out by hand for each width.
// -----------------------------------------------------------------------------
module tb_datapath_seq;

  logic        clk;
  logic        reset;
  logic [15:0] din_a;
  logic [7:0]  din_b;
  logic [15:0] dout_a;
  logic [7:0]  dout_b;
  logic [2:0]  st_a;
  logic [2:0]  st_b;
  logic [2:0]  dbg_addr_a;
  logic [3:0]  dbg_addr_b;
  logic [15:0] dbg_a;
  logic [7:0]  dbg_b;

  int n_total;
  int n_bad;

  datapath_seq_if #(.WIDTH(16), .NREGS(8))  ifa ();
  datapath_seq_if #(.WIDTH(8),  .NREGS(16)) ifb ();

  datapath_seq #(.WIDTH(16), .NREGS(8)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .bus          (ifa.slave),
    .datapath_in  (din_a),
    .datapath_out (dout_a),
    .status       (st_a),
    .dbg_addr     (dbg_addr_a),
    .dbg_data     (dbg_a)
  );

  datapath_seq #(.WIDTH(8), .NREGS(16)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .bus          (ifb.slave),
    .datapath_in  (din_b),
    .datapath_out (dout_b),
    .status       (st_b),
    .dbg_addr     (dbg_addr_b),
    .dbg_data     (dbg_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] op, input logic [1:0] sh,
                         input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                         input logic az, input logic bi,
                         input logic [15:0] ia, input logic [7:0] ib,
                         input logic wr, input logic vs, input logic ld);
    ifa.req_op = op;      ifb.req_op = op;
    ifa.req_shift = sh;   ifb.req_shift = sh;
    ifa.req_rn = rn[2:0]; ifb.req_rn = rn;
    ifa.req_rm = rm[2:0]; ifb.req_rm = rm;
    ifa.req_rd = rd[2:0]; ifb.req_rd = rd;
    ifa.req_asel_zero = az; ifb.req_asel_zero = az;
    ifa.req_bsel_imm = bi;  ifb.req_bsel_imm = bi;
    ifa.req_imm = ia;       ifb.req_imm = ib;
    ifa.req_write = wr;     ifb.req_write = wr;
    ifa.req_vsel_in = vs;   ifb.req_vsel_in = vs;
    ifa.req_loads = ld;     ifb.req_loads = ld;
  endtask

  task automatic set_valid(input logic v);
    ifa.req_valid = v;
    ifb.req_valid = v;
  endtask

  // Called one time unit after a rising edge with both DUTs idle; returns one
  // time unit after the write-back edge E3, where done must be high.
  task automatic run_op(input logic [1:0] op, input logic [1:0] sh,
                        input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                        input logic az, input logic bi,
                        input logic [15:0] ia, input logic [7:0] ib,
                        input logic wr, input logic vs, input logic ld);
    set_req(op, sh, rn, rm, rd, az, bi, ia, ib, wr, vs, ld);
    set_valid(1'b1);
    @(posedge clk);
    #1 set_valid(1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("done_e2_a", ifa.done, 1'b0);
    chk("done_e2_b", ifb.done, 1'b0);
    @(posedge clk);
    #1;
    chk("done_e3_a", ifa.done, 1'b1);
    chk("done_e3_b", ifb.done, 1'b1);
  endtask

  task automatic chk_out(input string tag, input logic [15:0] ca, input logic [7:0] cb,
                         input logic [2:0] sa, input logic [2:0] sb);
    chk({tag, "_c16"}, dout_a, ca);
    chk({tag, "_c8"},  dout_b, cb);
    chk({tag, "_st16"}, st_a, sa);
    chk({tag, "_st8"},  st_b, sb);
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] addr,
                         input logic [15:0] ea, input logic [7:0] eb);
    dbg_addr_a = addr[2:0];
    dbg_addr_b = addr;
    #1;
    chk({tag, "_r16"}, dbg_a, ea);
    chk({tag, "_r8"},  dbg_b, eb);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_c16"}, dout_a, 16'h0);
    chk({tag, "_c8"},  dout_b, 8'h0);
    chk({tag, "_st16"}, st_a, 3'b000);
    chk({tag, "_st8"},  st_b, 3'b000);
    chk({tag, "_done16"}, ifa.done, 1'b0);
    chk({tag, "_done8"},  ifb.done, 1'b0);
    chk({tag, "_rdy16"}, ifa.req_ready, 1'b1);
    chk({tag, "_rdy8"},  ifb.req_ready, 1'b1);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b1;
    din_a   = 16'h0;
    din_b   = 8'h0;
    dbg_addr_a = '0;
    dbg_addr_b = '0;
    set_valid(1'b0);
    set_req(2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0);

    #12;
    chk_reset_outputs("por");
    reset = 1'b0;
    #1;
    chk("por_rdy_after16", ifa.req_ready, 1'b1);
    chk("por_rdy_after8",  ifb.req_ready, 1'b1);
    @(posedge clk);
    #1;

    // Immediate load, loads=0 keeps status at 000
    run_op(2'd0, 2'd0, 4'd0, 4'd0, 4'd1, 1'b1, 1'b1, 16'h0007, 8'h07, 1'b1, 1'b0, 1'b0);
    chk_out("ld7", 16'h0007, 8'h07, 3'b000, 3'b000);
    chk_reg("ld7", 4'd1, 16'h0007, 8'h07);

    run_op(2'd0, 2'd0, 4'd0, 4'd0, 4'd2, 1'b1, 1'b1, 16'h0004, 8'h04, 1'b1, 1'b0, 1'b0);
    chk_reg("ld4", 4'd2, 16'h0004, 8'h04);

    // SUB r1 - (r2 << 1) = 7 - 8 = -1
    run_op(2'd1, 2'd1, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 1'b1);
    chk_out("sub_lsl", 16'hFFFF, 8'hFF, 3'b010, 3'b010);
    chk_reg("sub_lsl", 4'd3, 16'hFFFF, 8'hFF);

    // AND r3, #0 -> zero; write=0 leaves r7 alone
    run_op(2'd2, 2'd0, 4'd3, 4'd0, 4'd7, 1'b0, 1'b1, 16'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    chk_out("and_z", 16'h0000, 8'h00, 3'b001, 3'b001);
    chk_reg("and_nowr", 4'd7, 16'h0000, 8'h00);

    // Load max positive, loads=0 must hold Z
    run_op(2'd0, 2'd0, 4'd0, 4'd0, 4'd1, 1'b1, 1'b1, 16'h7FFF, 8'h7F, 1'b1, 1'b0, 1'b0);
    chk_out("ldmax_hold", 16'h7FFF, 8'h7F, 3'b001, 3'b001);

    // ADD overflow: max + 1
    run_op(2'd0, 2'd0, 4'd1, 4'd0, 4'd4, 1'b0, 1'b1, 16'h0001, 8'h01, 1'b1, 1'b0, 1'b1);
    chk_out("add_ovf", 16'h8000, 8'h80, 3'b110, 3'b110);
    chk_reg("add_ovf", 4'd4, 16'h8000, 8'h80);

    // MVN of 0
    run_op(2'd3, 2'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 16'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    chk_out("mvn0", 16'hFFFF, 8'hFF, 3'b010, 3'b010);

    // SUB overflow: 0 - most-negative
    run_op(2'd1, 2'd0, 4'd0, 4'd4, 4'd0, 1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    chk_out("sub_ovf", 16'h8000, 8'h80, 3'b110, 3'b110);

    // ASR1 of all-ones stays all-ones; LSR1 zero-fills
    run_op(2'd0, 2'd3, 4'd0, 4'd3, 4'd0, 1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    chk_out("asr", 16'hFFFF, 8'hFF, 3'b010, 3'b010);
    run_op(2'd0, 2'd2, 4'd0, 4'd3, 4'd0, 1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    chk_out("lsr", 16'h7FFF, 8'h7F, 3'b000, 3'b000);

    // rn == rm == rd: r1 = r1 + r1 with the old r1
    run_op(2'd0, 2'd0, 4'd1, 4'd1, 4'd1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 1'b1);
    chk_out("self", 16'hFFFE, 8'hFE, 3'b110, 3'b110);
    chk_reg("self", 4'd1, 16'hFFFE, 8'hFE);

    // Reset while idle with populated registers and done still high
    #1 reset = 1'b1;
    #2;
    chk_reset_outputs("idle_rst");
    for (int i = 0; i < 16; i++) begin
      dbg_addr_a = i[2:0];
      dbg_addr_b = i[3:0];
      #1;
      chk("idle_rst_dbg8", dbg_b, 8'h00);
      if (i < 8) chk("idle_rst_dbg16", dbg_a, 16'h0000);
    end
    reset = 1'b0;
    #1;
    chk("idle_rst_rdy16", ifa.req_ready, 1'b1);
    chk("idle_rst_rdy8",  ifb.req_ready, 1'b1);
    @(posedge clk);
    #1;

    // Handshake: req_valid held through two ops, op2 reads op1's rd
    din_a = 16'hAAAA;
    din_b = 8'hAA;
    set_req(2'd0, 2'd0, 4'd0, 4'd0, 4'd5, 1'b1, 1'b1, 16'h0005, 8'h05, 1'b1, 1'b0, 1'b0);
    set_valid(1'b1);
    @(posedge clk);                       // E0
    #1;
    chk("hs_rdy_e0_16", ifa.req_ready, 1'b0);
    chk("hs_rdy_e0_8",  ifb.req_ready, 1'b0);
    set_req(2'd0, 2'd0, 4'd5, 4'd0, 4'd6, 1'b0, 1'b1, 16'h0001, 8'h01, 1'b1, 1'b1, 1'b1);
    @(posedge clk);                       // E1
    #1;
    chk("hs_rdy_e1_16", ifa.req_ready, 1'b0);
    chk("hs_rdy_e1_8",  ifb.req_ready, 1'b0);
    @(posedge clk);                       // E2
    #1;
    chk("hs_rdy_e2_16", ifa.req_ready, 1'b0);
    chk("hs_rdy_e2_8",  ifb.req_ready, 1'b0);
    @(posedge clk);                       // E3
    #1;
    chk("hs_rdy_e3_16", ifa.req_ready, 1'b1);
    chk("hs_rdy_e3_8",  ifb.req_ready, 1'b1);
    chk("hs_done1_16", ifa.done, 1'b1);
    chk("hs_done1_8",  ifb.done, 1'b1);
    chk_reg("hs_op1", 4'd5, 16'h0005, 8'h05);
    @(posedge clk);                       // E4: op2 accepted
    #1;
    set_valid(1'b0);
    chk("hs_rdy_e4_16", ifa.req_ready, 1'b0);
    chk("hs_rdy_e4_8",  ifb.req_ready, 1'b0);
    chk("hs_done_e4_16", ifa.done, 1'b0);
    chk("hs_done_e4_8",  ifb.done, 1'b0);
    @(posedge clk);                       // E5
    @(posedge clk);                       // E6
    #1;
    chk("hs_done_e6_16", ifa.done, 1'b0);
    chk("hs_done_e6_8",  ifb.done, 1'b0);
    din_a = 16'h1234;
    din_b = 8'h34;
    @(posedge clk);                       // E7: op2 write-back
    #1;
    din_a = 16'hBEEF;
    din_b = 8'hEF;
    chk("hs_done2_16", ifa.done, 1'b1);
    chk("hs_done2_8",  ifb.done, 1'b1);
    chk("hs_rdy_e7_16", ifa.req_ready, 1'b1);
    chk("hs_rdy_e7_8",  ifb.req_ready, 1'b1);
    chk_out("hs_op2", 16'h0006, 8'h06, 3'b000, 3'b000);
    chk_reg("hs_vsel", 4'd6, 16'h1234, 8'h34);

    // Reset during EXEC of a write op aborts it
    set_req(2'd0, 2'd0, 4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 16'h0055, 8'h55, 1'b1, 1'b0, 1'b1);
    set_valid(1'b1);
    @(posedge clk);                       // E0
    #1 set_valid(1'b0);
    @(posedge clk);                       // E1: now in EXEC
    #2 reset = 1'b1;
    #2;
    chk_reset_outputs("exec_rst");
    #3 reset = 1'b0;
    #1;
    chk("exec_rst_rdy16", ifa.req_ready, 1'b1);
    chk("exec_rst_rdy8",  ifb.req_ready, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("exec_rst_nodone16", ifa.done, 1'b0);
      chk("exec_rst_nodone8",  ifb.done, 1'b0);
    end
    chk_reg("exec_rst_r7", 4'd7, 16'h0000, 8'h00);
    chk_out("exec_rst_hold", 16'h0000, 8'h00, 3'b000, 3'b000);

    // Recovery after reset
    run_op(2'd0, 2'd0, 4'd0, 4'd0, 4'd2, 1'b1, 1'b1, 16'h0009, 8'h09, 1'b1, 1'b0, 1'b1);
    chk_out("recover", 16'h0009, 8'h09, 3'b000, 3'b000);
    chk_reg("recover", 4'd2, 16'h0009, 8'h09);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
